cmp_delay_pipe: RTL and testbench

//  Multi-lane magnitude comparator behind an elastic, fixed-latency valid/ready pipeline.

---
 rtl/cmp_delay_pipe.sv | 141 ++++++++++++++
 tb/tb_cmp_delay_pipe.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_delay_pipe.sv
// cmp_delay_pipe: multi-lane gt/eq/lt/max comparator behind an elastic, fixed-latency valid/ready pipeline.
// Define CMP_DELAY_STATS_EN to add saturating output-handshake counters (stat_clr/stat_beats/stat_gt).
module cmp_delay_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned LANES  = 2,
  parameter int unsigned LAT    = 3,
  parameter bit          SIGNED = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES-1:0]       out_gt,
  output logic [LANES-1:0]       out_eq,
  output logic [LANES-1:0]       out_lt,
  output logic [LANES*WIDTH-1:0] out_max
`ifdef CMP_DELAY_STATS_EN
  ,
  input  logic                   stat_clr,
  output logic [15:0]            stat_beats,
  output logic [15:0]            stat_gt
`endif
);

  localparam int unsigned DW = LANES * WIDTH;
  localparam int unsigned RW = 3 * LANES + DW;

  logic [LAT-1:0]   r_v;
  logic [LAT-1:0]   w_adv;
  logic [DW-1:0]    r_a;
  logic [DW-1:0]    r_b;
  logic [LANES-1:0] w_gt;
  logic [LANES-1:0] w_eq;
  logic [LANES-1:0] w_lt;
  logic [DW-1:0]    w_max;
  logic [RW-1:0]    w_res;
  logic [RW-1:0]    w_last;

  // A stage may advance when it, or any stage downstream of it, is empty or the sink is ready.
  always_comb begin : adv_chain
    logic w_run;
    w_run = out_ready;
    w_adv = '0;
    for (int k = int'(LAT) - 1; k >= 0; k--) begin
      w_run    = w_run | ~r_v[k];
      w_adv[k] = w_run;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
      r_a <= '0;
      r_b <= '0;
    end else begin
      if (w_adv[0]) r_v[0] <= in_valid;
      for (int k = 1; k < int'(LAT); k++) begin
        if (w_adv[k]) r_v[k] <= r_v[k-1];
      end
      if (w_adv[0] && in_valid) begin
        r_a <= in_a;
        r_b <= in_b;
      end
    end
  end

  // Per-lane compare on the stage-0 operands; max picks A on a tie.
  always_comb begin
    w_gt  = '0;
    w_eq  = '0;
    w_lt  = '0;
    w_max = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      if (SIGNED) begin
        w_gt[l] = $signed(r_a[l*WIDTH +: WIDTH]) > $signed(r_b[l*WIDTH +: WIDTH]);
        w_lt[l] = $signed(r_a[l*WIDTH +: WIDTH]) < $signed(r_b[l*WIDTH +: WIDTH]);
      end else begin
        w_gt[l] = r_a[l*WIDTH +: WIDTH] > r_b[l*WIDTH +: WIDTH];
        w_lt[l] = r_a[l*WIDTH +: WIDTH] < r_b[l*WIDTH +: WIDTH];
      end
      w_eq[l] = r_a[l*WIDTH +: WIDTH] == r_b[l*WIDTH +: WIDTH];
      w_max[l*WIDTH +: WIDTH] = w_lt[l] ? r_b[l*WIDTH +: WIDTH] : r_a[l*WIDTH +: WIDTH];
    end
  end

  assign w_res = {w_gt, w_eq, w_lt, w_max};

  if (LAT == 1) begin : g_lat1
    assign w_last = w_res;
  end else begin : g_pipe
    // r_res[k-1] holds the result carried by stage k.
    logic [RW-1:0] r_res [LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(LAT) - 1; i++) r_res[i] <= '0;
      end else begin
        if (w_adv[1] && r_v[0]) r_res[0] <= w_res;
        for (int k = 2; k < int'(LAT); k++) begin
          if (w_adv[k] && r_v[k-1]) r_res[k-1] <= r_res[k-2];
        end
      end
    end

    assign w_last = r_res[LAT-2];
  end

  assign in_ready  = w_adv[0];
  assign out_valid = r_v[LAT-1];
  assign {out_gt, out_eq, out_lt, out_max} = r_v[LAT-1] ? w_last : '0;

`ifdef CMP_DELAY_STATS_EN
  logic        w_hs;
  logic [15:0] r_beats;
  logic [15:0] r_gtc;

  assign w_hs = out_valid & out_ready;

  // Saturating counters; a clear beats a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beats <= '0;
      r_gtc   <= '0;
    end else if (stat_clr) begin
      r_beats <= '0;
      r_gtc   <= '0;
    end else if (w_hs) begin
      if (r_beats != 16'hFFFF) r_beats <= r_beats + 16'd1;
      if ((|out_gt) && (r_gtc != 16'hFFFF)) r_gtc <= r_gtc + 16'd1;
    end
  end

  assign stat_beats = r_beats;
  assign stat_gt    = r_gtc;
`endif

endmodule

// File: tb/tb_cmp_delay_pipe.sv
// Scoreboard bench for cmp_delay_pipe: one unsigned and one signed instance share stimulus,
// and a monitor checks every output handshake against an arithmetic reference model.
`timescale 1ns/1ps
module tb_cmp_delay_pipe;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned LANES = 2;
  localparam int unsigned LAT   = 3;
  localparam int unsigned DW    = WIDTH * LANES;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;

  logic             u_in_ready, s_in_ready, u_ov, s_ov;
  logic [LANES-1:0] u_gt, u_eq, u_lt, s_gt, s_eq, s_lt;
  logic [DW-1:0]    u_max, s_max;
`ifdef CMP_DELAY_STATS_EN
  logic        stat_clr = 1'b0;
  logic        clr_next = 1'b0;
  logic [15:0] u_beats, u_sgt, s_beats, s_sgt;
`endif

  always #5 clk = ~clk;

  cmp_delay_pipe #(.WIDTH(WIDTH), .LANES(LANES), .LAT(LAT), .SIGNED(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u_in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(u_ov), .out_ready(out_ready),
    .out_gt(u_gt), .out_eq(u_eq), .out_lt(u_lt), .out_max(u_max)
`ifdef CMP_DELAY_STATS_EN
    , .stat_clr(stat_clr), .stat_beats(u_beats), .stat_gt(u_sgt)
`endif
  );

  cmp_delay_pipe #(.WIDTH(WIDTH), .LANES(LANES), .LAT(LAT), .SIGNED(1'b1)) s_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(s_ov), .out_ready(out_ready),
    .out_gt(s_gt), .out_eq(s_eq), .out_lt(s_lt), .out_max(s_max)
`ifdef CMP_DELAY_STATS_EN
    , .stat_clr(stat_clr), .stat_beats(s_beats), .stat_gt(s_sgt)
`endif
  );

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    bit            lat_chk;
    int            acc;
  } beat_t;

  beat_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int outs = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: interpret each lane as an integer, compare with plain arithmetic.
  function automatic void model(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit sgn,
                                output logic [LANES-1:0] gt, output logic [LANES-1:0] eq,
                                output logic [LANES-1:0] lt, output logic [DW-1:0] mx);
    gt = '0; eq = '0; lt = '0; mx = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      logic [WIDTH-1:0] ta, tb;
      longint av, bv;
      ta = a[l*WIDTH +: WIDTH];
      tb = b[l*WIDTH +: WIDTH];
      av = longint'(ta);
      bv = longint'(tb);
      if (sgn && av >= (longint'(1) << (WIDTH - 1))) av -= (longint'(1) << WIDTH);
      if (sgn && bv >= (longint'(1) << (WIDTH - 1))) bv -= (longint'(1) << WIDTH);
      gt[l] = av > bv;
      eq[l] = av == bv;
      lt[l] = av < bv;
      mx[l*WIDTH +: WIDTH] = (av >= bv) ? ta : tb;
    end
  endfunction

  function automatic logic [DW-1:0] rnd_op();
    logic [DW-1:0] v;
    v = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      case ($urandom_range(0, 5))
        0:       v[l*WIDTH +: WIDTH] = 8'h00;
        1:       v[l*WIDTH +: WIDTH] = 8'h7F;
        2:       v[l*WIDTH +: WIDTH] = 8'h80;
        3:       v[l*WIDTH +: WIDTH] = 8'hFF;
        default: v[l*WIDTH +: WIDTH] = 8'($urandom);
      endcase
    end
    return v;
  endfunction

  function automatic logic [DW-1:0] rnd_b(input logic [DW-1:0] a);
    logic [DW-1:0] v;
    v = rnd_op();
    for (int l = 0; l < int'(LANES); l++)
      if ($urandom_range(0, 3) == 0) v[l*WIDTH +: WIDTH] = a[l*WIDTH +: WIDTH];
    return v;
  endfunction

  // One cycle: drive after the falling edge, decide acceptance just before the rising edge.
  task automatic drive(input bit v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input bit ordy, input bit lchk, output bit acc);
    @(negedge clk);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    out_ready = ordy;
`ifdef CMP_DELAY_STATS_EN
    stat_clr  = clr_next;
`endif
    #4;
    acc = v && u_in_ready;
    if (acc) sb.push_back('{a, b, lchk, cyc + 1});
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) drive(1'b0, '0, '0, 1'b1, 1'b0, acc);
  endtask

  // Monitor: pops the scoreboard on every output handshake, checks stall stability.
  initial begin : monitor
    bit                held_v;
    logic [63:0]       held;
    beat_t             e;
    logic [LANES-1:0]  egt, eeq, elt;
    logic [DW-1:0]     emx;
`ifdef CMP_DELAY_STATS_EN
    logic [15:0]       m_beats, m_gt;
    bit                hs_gt;
    m_beats = '0;
    m_gt    = '0;
`endif
    held_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        held_v = 1'b0;
`ifdef CMP_DELAY_STATS_EN
        m_beats = '0;
        m_gt    = '0;
`endif
        continue;
      end
`ifdef CMP_DELAY_STATS_EN
      chk("stat_beats", 64'(u_beats), 64'(m_beats));
      chk("stat_gt", 64'(u_sgt), 64'(m_gt));
      hs_gt = 1'b0;
`endif
      if (held_v) begin
        chk("stall_valid", 64'(u_ov), 64'd1);
        chk("stall_hold", 64'({u_gt, u_eq, u_lt, u_max}), held);
      end
      held_v = 1'b0;
      if (u_ov && !out_ready) begin
        held_v = 1'b1;
        held   = 64'({u_gt, u_eq, u_lt, u_max});
      end else if (u_ov && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", 64'(u_ov), 64'd0);
        end else begin
          e = sb.pop_front();
          outs++;
          model(e.a, e.b, 1'b0, egt, eeq, elt, emx);
          chk("u_gt", 64'(u_gt), 64'(egt));
          chk("u_eq", 64'(u_eq), 64'(eeq));
          chk("u_lt", 64'(u_lt), 64'(elt));
          chk("u_max", 64'(u_max), 64'(emx));
`ifdef CMP_DELAY_STATS_EN
          hs_gt = |egt;
`endif
          model(e.a, e.b, 1'b1, egt, eeq, elt, emx);
          chk("s_valid", 64'(s_ov), 64'd1);
          chk("s_gt", 64'(s_gt), 64'(egt));
          chk("s_eq", 64'(s_eq), 64'(eeq));
          chk("s_lt", 64'(s_lt), 64'(elt));
          chk("s_max", 64'(s_max), 64'(emx));
          if (e.lat_chk) chk("latency", 64'(cyc - e.acc), 64'(LAT - 1));
        end
      end
`ifdef CMP_DELAY_STATS_EN
      if (stat_clr) begin
        m_beats = '0;
        m_gt    = '0;
      end else if (u_ov && out_ready) begin
        if (m_beats != 16'hFFFF) m_beats = m_beats + 16'd1;
        if (hs_gt && m_gt != 16'hFFFF) m_gt = m_gt + 16'd1;
      end
`endif
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit acc;
    int idx;
    int outs0;
    logic [DW-1:0] pa [5];
    logic [DW-1:0] pb [5];

    // Reset state and first cycle after release.
    repeat (3) @(negedge clk);
    #4;
    chk("rst_out_valid", 64'(u_ov), 64'd0);
    chk("rst_outs", 64'({u_gt, u_eq, u_lt, u_max}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #4;
    chk("rst_in_ready", 64'(u_in_ready), 64'd1);

    // Latency and basic compare, then equal/signed boundary.
    drive(1'b1, {8'd3, 8'd1}, {8'd2, 8'd2}, 1'b1, 1'b1, acc);
    chk("t2_accept", 64'(acc), 64'd1);
    idle(LAT + 1);
    drive(1'b1, {8'd5, 8'h80}, {8'd5, 8'h7F}, 1'b1, 1'b1, acc);
    chk("t3_accept", 64'(acc), 64'd1);
    idle(LAT + 1);

    // Backpressure: only LAT beats fit, the rest wait, all emerge in order.
    pa[0] = {8'd2, 8'd1}; pb[0] = {8'd1, 8'd2};
    pa[1] = {8'd1, 8'd1}; pb[1] = {8'd1, 8'd1};
    pa[2] = {8'd2, 8'd3}; pb[2] = {8'd3, 8'd2};
    pa[3] = {8'd2, 8'd4}; pb[3] = {8'd4, 8'd2};
    pa[4] = {8'd3, 8'd5}; pb[4] = {8'd5, 8'd3};
    outs0 = outs;
    idx = 0;
    repeat (6) begin
      if (idx < 5) drive(1'b1, pa[idx], pb[idx], 1'b0, 1'b0, acc);
      else         drive(1'b0, '0, '0, 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    chk("t4_accepted", 64'(idx), 64'(LAT));
    chk("t4_full_in_ready", 64'(u_in_ready), 64'd0);
    for (int g = 0; g < 50 && idx < 5; g++) begin
      drive(1'b1, pa[idx], pb[idx], 1'b1, 1'b0, acc);
      if (acc) idx++;
    end
    idle(LAT + 2);
    chk("t4_drained", 64'(sb.size()), 64'd0);
    chk("t4_count", 64'(outs - outs0), 64'd5);

    // Full pipeline with sink ready: one in, one out per cycle.
    repeat (LAT) drive(1'b1, rnd_op(), rnd_op(), 1'b0, 1'b0, acc);
    repeat (20) begin
      drive(1'b1, rnd_op(), rnd_op(), 1'b1, 1'b1, acc);
      chk("t5_accept", 64'(acc), 64'd1);
    end
    idle(LAT + 2);
    chk("t5_drained", 64'(sb.size()), 64'd0);

    // Reset with two beats in flight.
    repeat (2) drive(1'b1, rnd_op(), rnd_op(), 1'b0, 1'b0, acc);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(u_ov), 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #4;
    chk("midrst_in_ready", 64'(u_in_ready), 64'd1);
    idle(LAT + 2);
    chk("midrst_no_stale", 64'(u_ov), 64'd0);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 600; i++) begin
      logic [DW-1:0] a;
      a = rnd_op();
      drive($urandom_range(0, 3) != 0, a, rnd_b(a), $urandom_range(0, 2) != 0, 1'b0, acc);
    end
    idle(LAT + 4);
    chk("rand_drained", 64'(sb.size()), 64'd0);

`ifdef CMP_DELAY_STATS_EN
    clr_next = 1'b1;
    idle(1);
    clr_next = 1'b0;
    drive(1'b1, {8'd5, 8'd5}, {8'd3, 8'd3}, 1'b1, 1'b0, acc);
    drive(1'b1, {8'd2, 8'd2}, {8'd9, 8'd9}, 1'b1, 1'b0, acc);
    drive(1'b1, {8'd7, 8'd7}, {8'd1, 8'd1}, 1'b1, 1'b0, acc);
    drive(1'b1, {8'd9, 8'd9}, {8'd2, 8'd2}, 1'b1, 1'b0, acc);
    idle(LAT + 2);
    chk("t6_beats", 64'(u_beats), 64'd4);
    chk("t6_gt", 64'(u_sgt), 64'd3);
    repeat (LAT + 1) drive(1'b1, rnd_op(), rnd_op(), 1'b1, 1'b0, acc);
    clr_next = 1'b1;
    drive(1'b1, rnd_op(), rnd_op(), 1'b1, 1'b0, acc);
    clr_next = 1'b0;
    chk("t6_clr_hs", 64'(u_ov), 64'd1);
    drive(1'b0, '0, '0, 1'b0, 1'b0, acc);
    chk("t6_clr_beats", 64'(u_beats), 64'd0);
    chk("t6_clr_gt", 64'(u_sgt), 64'd0);
    repeat (65540) drive(1'b1, rnd_op(), rnd_op(), 1'b1, 1'b0, acc);
    idle(LAT + 2);
    chk("t6_sat", 64'(u_beats), 64'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
